// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage_if
// Description : Signal bundle between the decode stage, the forwarding
//               sources (EX/MEM and MEM/WB) and the ID/EX pipeline register.
//               master : drives the ID fields, flush and forwarding sources,
//                        and observes the stall and EX-stage outputs.
//               slave  : the id_ex_stage block itself.
// Ports       : flush, id_* (decoded instruction), exmem_* / memwb_*
//               (forwarding sources) -> stage; id_stall, ex_* (EX operands
//               and controls), fwd_a_sel / fwd_b_sel <- stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_stage_if #(
  parameter int REG_WIDTH       = 32,
  parameter int ALU_OPSEL_WIDTH = 4,
  parameter int RADDR_WIDTH     = 5
);
  logic                       flush;
  logic                       id_valid;
  logic [RADDR_WIDTH-1:0]     id_rs_addr;
  logic [RADDR_WIDTH-1:0]     id_rt_addr;
  logic [RADDR_WIDTH-1:0]     id_rd_addr;
  logic [REG_WIDTH-1:0]       id_rs_data;
  logic [REG_WIDTH-1:0]       id_rt_data;
  logic [REG_WIDTH-1:0]       id_imm;
  logic                       id_use_imm;
  logic [ALU_OPSEL_WIDTH-1:0] id_alu_opsel;
  logic                       id_reg_write;
  logic                       id_mem_read;
  logic                       exmem_reg_write;
  logic [RADDR_WIDTH-1:0]     exmem_rd;
  logic [REG_WIDTH-1:0]       exmem_result;
  logic                       memwb_reg_write;
  logic [RADDR_WIDTH-1:0]     memwb_rd;
  logic [REG_WIDTH-1:0]       memwb_result;
  logic                       id_stall;
  logic                       ex_valid;
  logic [REG_WIDTH-1:0]       ex_op_a;
  logic [REG_WIDTH-1:0]       ex_op_b;
  logic [ALU_OPSEL_WIDTH-1:0] ex_alu_opsel;
  logic [RADDR_WIDTH-1:0]     ex_rd_addr;
  logic                       ex_reg_write;
  logic                       ex_mem_read;
  logic [1:0]                 fwd_a_sel;
  logic [1:0]                 fwd_b_sel;

  modport master (
    output flush, id_valid, id_rs_addr, id_rt_addr, id_rd_addr,
           id_rs_data, id_rt_data, id_imm, id_use_imm, id_alu_opsel,
           id_reg_write, id_mem_read,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  id_stall, ex_valid, ex_op_a, ex_op_b, ex_alu_opsel,
           ex_rd_addr, ex_reg_write, ex_mem_read, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  flush, id_valid, id_rs_addr, id_rt_addr, id_rd_addr,
           id_rs_data, id_rt_data, id_imm, id_use_imm, id_alu_opsel,
           id_reg_write, id_mem_read,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output id_stall, ex_valid, ex_op_a, ex_op_b, ex_alu_opsel,
           ex_rd_addr, ex_reg_write, ex_mem_read, fwd_a_sel, fwd_b_sel
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use hazard detection and
//               operand forwarding from the EX/MEM and MEM/WB stages.
// Ports       : clk    - clock, all state on rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - id_ex_stage_if.slave: ID fields, flush, forwarding
//                        sources in; id_stall, EX operands/controls and
//                        forwarding selects out
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int REG_WIDTH       = 32,
  parameter int ALU_OPSEL_WIDTH = 4,
  parameter int RADDR_WIDTH     = 5
) (
  input  wire logic clk,
  input  wire logic rst_n,
  id_ex_stage_if.slave bus
);

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_MEMWB = 2'd1;
  localparam logic [1:0] FWD_EXMEM = 2'd2;

  // Pipeline register contents
  logic                       r_valid;
  logic [RADDR_WIDTH-1:0]     r_rs_addr;
  logic [RADDR_WIDTH-1:0]     r_rt_addr;
  logic [RADDR_WIDTH-1:0]     r_rd_addr;
  logic [REG_WIDTH-1:0]       r_rs_data;
  logic [REG_WIDTH-1:0]       r_rt_data;
  logic [REG_WIDTH-1:0]       r_imm;
  logic                       r_use_imm;
  logic [ALU_OPSEL_WIDTH-1:0] r_alu_opsel;
  logic                       r_reg_write;
  logic                       r_mem_read;

  logic                       w_load_use;
  logic                       w_capture;
  logic [1:0]                 w_fwd_a_sel;
  logic [1:0]                 w_fwd_rt_sel;
  logic [REG_WIDTH-1:0]       w_rt_fwd;

  // A live load in EX whose destination is read by the instruction in ID.
  // rt only counts when ID actually consumes it (not when op_b is the imm).
  assign w_load_use = bus.id_valid & r_valid & r_mem_read
                    & (r_rd_addr != '0)
                    & ((r_rd_addr == bus.id_rs_addr)
                       | ((r_rd_addr == bus.id_rt_addr) & ~bus.id_use_imm));

  // Flush overrides the stall: the ID instruction is being killed anyway.
  assign bus.id_stall = w_load_use & ~bus.flush;

  // Only a real, non-stalled, non-flushed instruction becomes live in EX;
  // every other case loads a bubble with its controls cleared.
  assign w_capture = bus.id_valid & ~w_load_use & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_alu_opsel <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else begin
      // Data fields load every cycle; they are don't-care inside a bubble.
      r_valid     <= w_capture;
      r_rs_addr   <= bus.id_rs_addr;
      r_rt_addr   <= bus.id_rt_addr;
      r_rd_addr   <= bus.id_rd_addr;
      r_rs_data   <= bus.id_rs_data;
      r_rt_data   <= bus.id_rt_data;
      r_imm       <= bus.id_imm;
      r_use_imm   <= bus.id_use_imm;
      r_alu_opsel <= bus.id_alu_opsel;
      r_reg_write <= bus.id_reg_write & w_capture;
      r_mem_read  <= bus.id_mem_read & w_capture;
    end
  end

  // Forwarding: EX/MEM is the younger result so it wins over MEM/WB.
  // Register 0 is hard-wired and never forwarded.
  always_comb begin
    w_fwd_a_sel = FWD_REG;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rs_addr))
      w_fwd_a_sel = FWD_EXMEM;
    else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rs_addr))
      w_fwd_a_sel = FWD_MEMWB;

    w_fwd_rt_sel = FWD_REG;
    if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == r_rt_addr))
      w_fwd_rt_sel = FWD_EXMEM;
    else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == r_rt_addr))
      w_fwd_rt_sel = FWD_MEMWB;
  end

  always_comb begin
    case (w_fwd_a_sel)
      FWD_EXMEM: bus.ex_op_a = bus.exmem_result;
      FWD_MEMWB: bus.ex_op_a = bus.memwb_result;
      default:   bus.ex_op_a = r_rs_data;
    endcase

    case (w_fwd_rt_sel)
      FWD_EXMEM: w_rt_fwd = bus.exmem_result;
      FWD_MEMWB: w_rt_fwd = bus.memwb_result;
      default:   w_rt_fwd = r_rt_data;
    endcase
  end

  assign bus.ex_op_b      = r_use_imm ? r_imm : w_rt_fwd;
  assign bus.fwd_a_sel    = w_fwd_a_sel;
  // With an immediate operand rt is not used, so report no forwarding on B.
  assign bus.fwd_b_sel    = r_use_imm ? FWD_REG : w_fwd_rt_sel;

  assign bus.ex_valid     = r_valid;
  assign bus.ex_alu_opsel = r_alu_opsel;
  assign bus.ex_rd_addr   = r_rd_addr;
  assign bus.ex_reg_write = r_reg_write & r_valid;
  assign bus.ex_mem_read  = r_mem_read & r_valid;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. Directed scenarios with
//               literal expectations, then a randomized run compared every
//               cycle against a behavioural model of the EX-stage contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
  localparam int RW = 32;
  localparam int OW = 4;
  localparam int AW = 5;
  localparam int N_RANDOM = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.REG_WIDTH(RW), .ALU_OPSEL_WIDTH(OW), .RADDR_WIDTH(AW)) bus ();

  id_ex_stage #(.REG_WIDTH(RW), .ALU_OPSEL_WIDTH(OW), .RADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural view of the instruction sitting in EX.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs, rt, rd;
    logic [RW-1:0] rs_d, rt_d, imm;
    logic          use_imm;
    logic [OW-1:0] op;
    logic          rw, mr;
  } ex_t;
  ex_t m;

  // Which source supplies register `a`: 2 EX/MEM, 1 MEM/WB, 0 register file.
  function automatic logic [1:0] src_of(input logic [AW-1:0] a);
    if (a == 0) return 2'd0;
    if (bus.exmem_reg_write && bus.exmem_rd == a) return 2'd2;
    if (bus.memwb_reg_write && bus.memwb_rd == a) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [RW-1:0] val_of(input logic [1:0] s, input logic [RW-1:0] rf);
    if (s == 2'd2) return bus.exmem_result;
    if (s == 2'd1) return bus.memwb_result;
    return rf;
  endfunction

  task automatic clear_inputs();
    bus.flush = 0; bus.id_valid = 0;
    bus.id_rs_addr = 0; bus.id_rt_addr = 0; bus.id_rd_addr = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_use_imm = 0; bus.id_alu_opsel = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
  endtask

  task automatic set_id(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic [RW-1:0] rs_d,
                        input logic [RW-1:0] rt_d, input logic [OW-1:0] op,
                        input logic rw, input logic mr);
    bus.id_valid = 1; bus.id_rs_addr = rs; bus.id_rt_addr = rt; bus.id_rd_addr = rd;
    bus.id_rs_data = rs_d; bus.id_rt_data = rt_d; bus.id_alu_opsel = op;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_use_imm = 0; bus.id_imm = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare DUT against the model for the current inputs; returns load-use.
  task automatic check_cycle(output logic ld);
    logic [1:0] sa, sb;
    ld = bus.id_valid && m.valid && m.mr && (m.rd != 0) &&
         ((m.rd == bus.id_rs_addr) || ((m.rd == bus.id_rt_addr) && !bus.id_use_imm));
    chk("id_stall", 32'(bus.id_stall), 32'(ld && !bus.flush));
    chk("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
    chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(m.valid && m.rw));
    chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(m.valid && m.mr));
    if (m.valid) begin
      sa = src_of(m.rs);
      sb = m.use_imm ? 2'd0 : src_of(m.rt);
      chk("fwd_a_sel", 32'(bus.fwd_a_sel), 32'(sa));
      chk("fwd_b_sel", 32'(bus.fwd_b_sel), 32'(sb));
      chk("ex_op_a", bus.ex_op_a, val_of(sa, m.rs_d));
      chk("ex_op_b", bus.ex_op_b, m.use_imm ? m.imm : val_of(src_of(m.rt), m.rt_d));
      chk("ex_alu_opsel", 32'(bus.ex_alu_opsel), 32'(m.op));
      chk("ex_rd_addr", 32'(bus.ex_rd_addr), 32'(m.rd));
    end
  endtask

  task automatic update_model(input logic ld);
    if (bus.flush || ld || !bus.id_valid) begin
      m.valid = 0; m.rw = 0; m.mr = 0;
    end else begin
      m.valid = 1;
      m.rs = bus.id_rs_addr; m.rt = bus.id_rt_addr; m.rd = bus.id_rd_addr;
      m.rs_d = bus.id_rs_data; m.rt_d = bus.id_rt_data; m.imm = bus.id_imm;
      m.use_imm = bus.id_use_imm; m.op = bus.id_alu_opsel;
      m.rw = bus.id_reg_write; m.mr = bus.id_mem_read;
    end
  endtask

  task automatic randomize_inputs(input logic hold_id);
    if (!hold_id) begin
      bus.id_valid     = ($urandom_range(0, 9) < 8);
      bus.id_rs_addr   = AW'($urandom_range(0, 7));
      bus.id_rt_addr   = AW'($urandom_range(0, 7));
      bus.id_rd_addr   = AW'($urandom_range(0, 7));
      bus.id_rs_data   = $urandom;
      bus.id_rt_data   = $urandom;
      bus.id_imm       = $urandom;
      bus.id_use_imm   = $urandom_range(0, 1) == 1;
      bus.id_alu_opsel = OW'($urandom_range(0, 15));
      bus.id_reg_write = $urandom_range(0, 3) != 0;
      bus.id_mem_read  = $urandom_range(0, 2) == 0;
    end
    bus.flush           = $urandom_range(0, 15) == 0;
    bus.exmem_reg_write = $urandom_range(0, 1) == 1;
    bus.exmem_rd        = AW'($urandom_range(0, 7));
    bus.exmem_result    = $urandom;
    bus.memwb_reg_write = $urandom_range(0, 1) == 1;
    bus.memwb_rd        = AW'($urandom_range(0, 7));
    bus.memwb_result    = $urandom;
  endtask

  initial begin
    logic ld;
    logic hold;
    clear_inputs();
    m = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst ex_valid", 32'(bus.ex_valid), 0);
    chk("rst ex_op_a", bus.ex_op_a, 0);
    chk("rst ex_op_b", bus.ex_op_b, 0);
    chk("rst ex_rd_addr", 32'(bus.ex_rd_addr), 0);
    @(negedge clk);
    rst_n = 1;

    // Plain capture
    set_id(5'd3, 5'd4, 5'd10, 32'h11, 32'h22, 4'h2, 1'b1, 1'b0);
    tick();
    chk("cap ex_valid", 32'(bus.ex_valid), 1);
    chk("cap ex_op_a", bus.ex_op_a, 32'h11);
    chk("cap ex_op_b", bus.ex_op_b, 32'h22);
    chk("cap ex_alu_opsel", 32'(bus.ex_alu_opsel), 32'h2);
    chk("cap fwd_a_sel", 32'(bus.fwd_a_sel), 0);
    chk("cap fwd_b_sel", 32'(bus.fwd_b_sel), 0);

    // Double forward on rs=5
    set_id(5'd5, 5'd6, 5'd11, 32'h1234, 32'h5678, 4'h1, 1'b1, 1'b0);
    tick();
    bus.exmem_reg_write = 1; bus.exmem_rd = 5; bus.exmem_result = 32'hAAAA;
    bus.memwb_reg_write = 1; bus.memwb_rd = 5; bus.memwb_result = 32'hBBBB;
    #1;
    chk("dfwd ex_op_a", bus.ex_op_a, 32'hAAAA);
    chk("dfwd fwd_a_sel", 32'(bus.fwd_a_sel), 2);
    bus.exmem_rd = 0;
    #1;
    chk("dfwd r0 ex_op_a", bus.ex_op_a, 32'hBBBB);
    chk("dfwd r0 fwd_a_sel", 32'(bus.fwd_a_sel), 1);
    clear_inputs();

    // Load-use: lw rd=7 then add rs=7
    set_id(5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
    tick();
    set_id(5'd7, 5'd2, 5'd8, 32'h55, 32'h66, 4'h3, 1'b1, 1'b0);
    #1;
    chk("lu id_stall", 32'(bus.id_stall), 1);
    tick();
    chk("lu bubble ex_valid", 32'(bus.ex_valid), 0);
    chk("lu bubble ex_reg_write", 32'(bus.ex_reg_write), 0);
    chk("lu after id_stall", 32'(bus.id_stall), 0);
    tick();
    chk("lu add ex_valid", 32'(bus.ex_valid), 1);
    chk("lu add ex_rd_addr", 32'(bus.ex_rd_addr), 8);

    // Flush during load-use
    set_id(5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
    tick();
    set_id(5'd7, 5'd2, 5'd8, 32'h55, 32'h66, 4'h3, 1'b1, 1'b0);
    bus.flush = 1;
    #1;
    chk("flush id_stall", 32'(bus.id_stall), 0);
    tick();
    bus.flush = 0;
    chk("flush ex_valid", 32'(bus.ex_valid), 0);

    // Immediate operand with rt matching a load and the EX/MEM source
    set_id(5'd1, 5'd2, 5'd9, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
    tick();
    set_id(5'd1, 5'd9, 5'd12, 32'h1, 32'h2, 4'h4, 1'b1, 1'b0);
    bus.id_use_imm = 1; bus.id_imm = 32'hFFFF_FFF0;
    #1;
    chk("imm id_stall", 32'(bus.id_stall), 0);
    tick();
    bus.exmem_reg_write = 1; bus.exmem_rd = 9; bus.exmem_result = 32'hDEAD;
    #1;
    chk("imm ex_op_b", bus.ex_op_b, 32'hFFFF_FFF0);
    chk("imm fwd_b_sel", 32'(bus.fwd_b_sel), 0);
    clear_inputs();

    // Async reset in the middle of a stall, then normal capture
    set_id(5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 4'h5, 1'b1, 1'b1);
    tick();
    set_id(5'd7, 5'd2, 5'd8, 32'h77, 32'h88, 4'h6, 1'b1, 1'b0);
    #1;
    rst_n = 0;
    #1;
    chk("arst ex_valid", 32'(bus.ex_valid), 0);
    chk("arst ex_op_a", bus.ex_op_a, 0);
    chk("arst ex_op_b", bus.ex_op_b, 0);
    chk("arst ex_alu_opsel", 32'(bus.ex_alu_opsel), 0);
    chk("arst ex_rd_addr", 32'(bus.ex_rd_addr), 0);
    chk("arst ex_mem_read", 32'(bus.ex_mem_read), 0);
    chk("arst id_stall", 32'(bus.id_stall), 0);
    #1;
    rst_n = 1;
    tick();
    chk("arst recap ex_valid", 32'(bus.ex_valid), 1);
    chk("arst recap ex_rd_addr", 32'(bus.ex_rd_addr), 8);
    chk("arst recap ex_op_a", bus.ex_op_a, 32'h77);

    // Randomized run against the model, starting from a fresh reset
    @(negedge clk);
    clear_inputs();
    rst_n = 0;
    m = '0;
    @(negedge clk);
    rst_n = 1;
    hold = 0;
    for (int i = 0; i < N_RANDOM; i++) begin
      randomize_inputs(hold);
      #1;
      check_cycle(ld);
      @(posedge clk);
      update_model(ld);
      // A stalled ID instruction re-presents unchanged next cycle.
      hold = ld && !bus.flush;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
